// File: rtl/rv_pkg.sv
// rv_pkg: load funct3 encodings and writeback-stage state type shared by the L3 writeback logic.
package rv_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  typedef enum logic [1:0] {IDLE, LOAD_REQ, LOAD_WAIT, LOAD_WB} wb_state_t;
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = 8'(data >> {addr, 3'b000});
  assign h = addr[1] ? data[31:16] : data[15:0];
  // reserved encodings fall through to the full word
  assign result = funct3 == LB  ? {{24{b[7]}}, b} :
                  funct3 == LBU ? {24'd0, b} :
                  funct3 == LH  ? {{16{h[15]}}, h} :
                  funct3 == LHU ? {16'd0, h} : data;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: L3 writeback stage with a blocking data-memory load FSM and L2 forwarding source.
// Defining WB_STALL_CNT_EN adds a free-running stall_cnt output counting stalled cycles.
module wb_stage
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_l2,
  input  logic [4:0]  rd_l2,
  input  logic        we_l2,
  input  logic [31:0] alu_res_l2,
  input  logic        is_load_l2,
  input  logic [2:0]  funct3_l2,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall_l2,
  output logic [4:0]  rd_l3,
  output logic [31:0] wval_l3,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        misalign_l3
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  wb_state_t   state_q, state_d;
  logic [4:0]  ld_rd_q;
  logic        ld_we_q;
  logic [2:0]  ld_f3_q;
  logic [31:0] ld_addr_q;
  logic        accept, misalign;
  logic        rf_we_d, misalign_d;
  logic [4:0]  rf_waddr_d;
  logic [31:0] rf_wdata_d, ld_data;
  load_align u_align (
    .data   (mem_rdata),
    .addr   (ld_addr_q[1:0]),
    .funct3 (ld_f3_q),
    .result (ld_data)
  );
  assign stall_l2 = state_q == LOAD_REQ || state_q == LOAD_WAIT;
  assign accept   = valid_l2 && !stall_l2 && !flush;
  assign misalign = ((funct3_l2 == LH || funct3_l2 == LHU) && alu_res_l2[0]) ||
                    (funct3_l2 == LW && alu_res_l2[1:0] != 2'b00);
  assign mem_req  = state_q == LOAD_REQ;
  assign mem_addr = mem_req ? {ld_addr_q[31:2], 2'b00} : 32'd0;
  // x0 writes, bubbles and in-flight loads all present rd_l3 = 0 so they never forward
  assign rd_l3    = rf_we ? rf_waddr : 5'd0;
  assign wval_l3  = rf_wdata;
  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr;
    rf_wdata_d = rf_wdata;
    misalign_d = 1'b0;
    case (state_q)
      LOAD_REQ:  state_d = LOAD_WAIT;
      LOAD_WAIT: if (mem_rvalid) begin
        state_d    = LOAD_WB;
        rf_we_d    = ld_we_q;
        rf_waddr_d = ld_rd_q;
        rf_wdata_d = ld_data;
      end
      default: begin
        state_d = IDLE;
        if (accept && !is_load_l2) begin
          rf_we_d    = we_l2 && rd_l2 != 5'd0;
          rf_waddr_d = rd_l2;
          rf_wdata_d = alu_res_l2;
        end else if (accept) begin
          misalign_d = misalign;
          state_d    = misalign ? IDLE : LOAD_REQ;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'd0;
      misalign_l3 <= 1'b0;
      ld_rd_q     <= 5'd0;
      ld_we_q     <= 1'b0;
      ld_f3_q     <= 3'd0;
      ld_addr_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      rf_we       <= rf_we_d;
      rf_waddr    <= rf_waddr_d;
      rf_wdata    <= rf_wdata_d;
      misalign_l3 <= misalign_d;
      if (accept) begin
        ld_rd_q   <= rd_l2;
        ld_we_q   <= we_l2 && rd_l2 != 5'd0;
        ld_f3_q   <= funct3_l2;
        ld_addr_q <= alu_res_l2;
      end
    end
  end
`ifdef WB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= 32'd0;
    else if (stall_l2) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of ALU writeback, aligned/misaligned loads, flush and reset in LOAD_WAIT.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_l2 = 1'b0;
  logic [4:0]  rd_l2 = 5'd0;
  logic        we_l2 = 1'b0;
  logic [31:0] alu_res_l2 = 32'd0;
  logic        is_load_l2 = 1'b0;
  logic [2:0]  funct3_l2 = 3'd0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        stall_l2;
  logic [4:0]  rd_l3;
  logic [31:0] wval_l3;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_l3;
  int          checks = 0;
  int          errors = 0;
  int          req_pulses = 0;
`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .valid_l2    (valid_l2),
    .rd_l2       (rd_l2),
    .we_l2       (we_l2),
    .alu_res_l2  (alu_res_l2),
    .is_load_l2  (is_load_l2),
    .funct3_l2   (funct3_l2),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .stall_l2    (stall_l2),
    .rd_l3       (rd_l3),
    .wval_l3     (wval_l3),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .misalign_l3 (misalign_l3)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic alu(input logic [4:0] r, input logic w, input logic [31:0] v);
    valid_l2 = 1'b1; is_load_l2 = 1'b0; rd_l2 = r; we_l2 = w; alu_res_l2 = v;
  endtask
  task automatic ld(input logic [4:0] r, input logic [2:0] f3, input logic [31:0] a);
    valid_l2 = 1'b1; is_load_l2 = 1'b1; rd_l2 = r; we_l2 = 1'b1; funct3_l2 = f3; alu_res_l2 = a;
  endtask
  task automatic idle();
    valid_l2 = 1'b0; is_load_l2 = 1'b0;
  endtask
  // accept, LOAD_REQ, one LOAD_WAIT cycle with rdata ready; returns in the LOAD_WB cycle
  task automatic quick_load(input logic [4:0] r, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic fl);
    ld(r, f3, a);
    tick();
    idle();
    tick();
    flush = fl; mem_rvalid = 1'b1; mem_rdata = d;
    tick();
    flush = 1'b0; mem_rvalid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rd_l3", 32'(rd_l3), 0);
    chk("rst_wval", wval_l3, 0);
    chk("rst_mem", {31'd0, mem_req} | mem_addr, 0);
    chk("rst_stall", 32'(stall_l2), 0);
    chk("rst_misalign", 32'(misalign_l3), 0);
    rst = 1'b0;
    alu(5'd5, 1'b1, 32'h1234);
    tick();
    chk("alu_rf_we", 32'(rf_we), 1);
    chk("alu_rd_l3", 32'(rd_l3), 5);
    chk("alu_wval", wval_l3, 32'h1234);
    idle();
    tick();
    chk("bubble_rf_we", 32'(rf_we), 0);
    chk("bubble_rd_l3", 32'(rd_l3), 0);
    alu(5'd0, 1'b1, 32'h55);
    tick();
    chk("x0_rf_we", 32'(rf_we), 0);
    chk("x0_rd_l3", 32'(rd_l3), 0);
    ld(5'd7, 3'b000, 32'h103);
    tick();
    if (mem_req) req_pulses++;
    chk("lb_req_addr", mem_addr, 32'h100);
    chk("lb_req_stall", 32'(stall_l2), 1);
    // stray rvalid in LOAD_REQ must be ignored; a held ALU op must wait out the stall
    alu(5'd9, 1'b1, 32'h999);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("lb_stray_rvalid", 32'(rf_we), 0);
    for (int i = 0; i < 3; i++) begin
      if (mem_req) req_pulses++;
      chk("lb_wait_stall", 32'(stall_l2), 1);
      if (i == 2) begin
        mem_rvalid = 1'b1; mem_rdata = 32'h80FFFF7F;
      end
      tick();
    end
    mem_rvalid = 1'b0;
    if (mem_req) req_pulses++;
    chk("lb_req_pulses", 32'(req_pulses), 1);
    chk("lb_wb_stall", 32'(stall_l2), 0);
    chk("lb_wb_rf_we", 32'(rf_we), 1);
    chk("lb_wb_rd_l3", 32'(rd_l3), 7);
    chk("lb_wb_data", wval_l3, 32'hFFFFFF80);
    tick();
    idle();
    chk("wb_accept_rd", 32'(rd_l3), 9);
    chk("wb_accept_data", wval_l3, 32'h999);
    tick();
    chk("post_bubble", 32'(rf_we), 0);
    quick_load(5'd3, 3'b101, 32'h2, 32'h80010203, 1'b0);
    chk("lhu_rd_l3", 32'(rd_l3), 3);
    chk("lhu_data", wval_l3, 32'h00008001);
    quick_load(5'd4, 3'b010, 32'h0, 32'h80010203, 1'b0);
    chk("lw_data", wval_l3, 32'h80010203);
    tick();
    ld(5'd6, 3'b010, 32'h6);
    tick();
    idle();
    chk("mis_flag", 32'(misalign_l3), 1);
    chk("mis_req", 32'(mem_req), 0);
    chk("mis_rf_we", 32'(rf_we), 0);
    chk("mis_stall", 32'(stall_l2), 0);
    tick();
    chk("mis_pulse_end", 32'(misalign_l3), 0);
    chk("mis_no_req", 32'(mem_req), 0);
    quick_load(5'd8, 3'b000, 32'h0, 32'h000000AA, 1'b1);
    chk("flush_rf_we", 32'(rf_we), 1);
    chk("flush_data", wval_l3, 32'hFFFFFFAA);
    tick();
`ifdef WB_STALL_CNT_EN
    chk("stall_cnt_total", stall_cnt, 32'd10);
`endif
    ld(5'd10, 3'b010, 32'h10);
    tick();
    idle();
    tick();
    chk("rst_wait_stall", 32'(stall_l2), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_abandon_stall", 32'(stall_l2), 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("rst_late_rvalid_we", 32'(rf_we), 0);
    chk("rst_late_rvalid_rd", 32'(rd_l3), 0);
`ifdef WB_STALL_CNT_EN
    chk("stall_cnt_reset", stall_cnt, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising edge), rst input 1 (active-high).
REQ-002 valid_l2 input 1 SHALL mean the L2 slot holds a real instruction.
REQ-003 rd_l2 input 5 SHALL give the destination register; we_l2 input 1 SHALL be its register-write enable.
REQ-004 alu_res_l2 input 32 SHALL give the ALU result, or the load address when is_load_l2 is high.
REQ-005 is_load_l2 input 1 SHALL mark a load; funct3_l2 input 3 SHALL give the load width and sign.
REQ-006 flush input 1 SHALL mean discard the current L2 instruction.
REQ-007 mem_req output 1, mem_addr output 32 (word-aligned), mem_rvalid input 1 and mem_rdata input 32 SHALL form the data-memory read port.
REQ-008 stall_l2 output 1 SHALL hold L2 and upstream stages.
REQ-009 rd_l3 output 5 and wval_l3 output 32 SHALL be the forwarding source consumed by the L2 operand forwarding logic.
REQ-010 rf_we output 1, rf_waddr output 5 and rf_wdata output 32 SHALL form the register-file write port.
REQ-011 misalign_l3 output 1 SHALL pulse for a misaligned load.

Function
REQ-012 Accept SHALL equal valid_l2 && !stall_l2 && !flush; L3 registers SHALL capture L2 fields only on accept.
REQ-013 FSM states SHALL be IDLE, LOAD_REQ, LOAD_WAIT and LOAD_WB; stall_l2 SHALL be 1 exactly in LOAD_REQ and LOAD_WAIT.
REQ-014 A non-load accept SHALL stay in IDLE, with rf_we=we && rd!=0, rf_waddr=rd and rf_wdata=alu_res in the next cycle: 1-cycle latency.
REQ-015 An aligned load accept SHALL move to LOAD_REQ; LOAD_REQ SHALL drive mem_req=1 for exactly one cycle with mem_addr={addr[31:2],2'b00}, then move to LOAD_WAIT.
REQ-016 LOAD_WAIT SHALL hold until mem_rvalid=1, then capture the extracted data and move to LOAD_WB.
REQ-017 mem_rvalid SHALL be ignored outside LOAD_WAIT.
REQ-018 LOAD_WB SHALL write back the load for one cycle, then go to IDLE.
REQ-019 LOAD_WB SHALL accept a new L2 instruction in the same cycle.
REQ-020 Load extraction SHALL follow funct3 and addr[1:0]:
- LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Reserved funct3 values behave as LW.
REQ-021 A misaligned load (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) SHALL stay in IDLE, issue no mem_req and no write, and assert misalign_l3 for one cycle.
REQ-022 rd_l3 SHALL equal rf_waddr when rf_we=1, else 5'd0; wval_l3 SHALL equal rf_wdata.
REQ-023 Forcing rd_l3 to 0 SHALL ensure that x0, bubbles and pending loads never forward.
REQ-024 flush SHALL only block accept; a load already in LOAD_REQ, LOAD_WAIT or LOAD_WB SHALL complete.
REQ-025 A cycle with no accept SHALL leave a bubble in the following cycle: rf_we=0, rd_l3=0.

Reset
REQ-026 On rst, state SHALL be IDLE, and all of these SHALL be 0: rf_we, rf_waddr, rf_wdata, rd_l3, wval_l3, mem_req, mem_addr, misalign_l3, stall_l2.
REQ-027 rst during LOAD_WAIT SHALL abandon the load without writeback; a later mem_rvalid SHALL be ignored.

Configuration
REQ-028 With WB_STALL_CNT_EN defined, output stall_cnt (32 bits) SHALL:
- reset to 0;
- increment each cycle stall_l2=1;
- wrap at 2^32-1.
REQ-029 Without WB_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent.

Structure
REQ-030 Shared package rv_pkg SHALL hold:
- funct3 load constants LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101;
- the wb_state_t enum.
REQ-031 The combinational byte/half extraction and extension SHALL be a sub-module, load_align.

Verification
REQ-032 ALU op: rd=5, we=1, res=0x1234 -> next cycle rf_we=1, rd_l3=5, wval_l3=0x1234.
REQ-033 ALU op with rd=0, we=1 -> rf_we=0, rd_l3=0.
REQ-034 LB at addr 0x103 with mem_rdata=0x80FF_FF7F after 3 wait cycles:
- mem_req pulses once with mem_addr=0x100;
- stall_l2 stays high until rvalid;
- LOAD_WB writes 0xFFFF_FF80.
REQ-035 Loads on mem_rdata=0x8001_0203:
- LHU at addr 0x2 -> 0x0000_8001;
- LW at addr 0x0 -> 0x8001_0203.
REQ-036 LW at addr 0x6 -> misalign_l3=1 for one cycle, no mem_req, rf_we=0.
REQ-037 Boundary cases:
- flush during LOAD_WAIT -> the load still writes back.
- rst during LOAD_WAIT, then rvalid -> no write.
- With WB_STALL_CNT_EN, stall_cnt equals the total stall cycles.
